// File: rtl/rom_stream_reader_pkg.sv
// Shared types and constants for the ROM stream reader and its 16x8 table.
package rom_stream_reader_pkg;

    localparam int unsigned ROM_ADDR_W = 4;
    localparam int unsigned ROM_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/rom_stream_reader.sv
// Reads a contiguous run of ROM words and streams them over valid/ready through
// a single output register stage.
module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              load;

    // The output register may refill whenever it is empty or being drained this cycle.
    assign load = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        if (abort) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            remaining_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ptr_d       = start_addr;
                        // A zero length selects the whole table.
                        remaining_d = (length == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                     : {1'b0, length};
                        state_d     = StRun;
                    end
                end
                StRun: begin
                    if (load) begin
                        out_data_d  = rom_data;
                        out_addr_d  = ptr_q;
                        out_last_d  = (remaining_q == (ADDR_W+1)'(1));
                        out_valid_d = 1'b1;
                        ptr_d       = ptr_q + ADDR_W'(1);
                        remaining_d = remaining_q - (ADDR_W+1)'(1);
                        if (remaining_q == (ADDR_W+1)'(1)) begin
                            state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign rom_addr  = ptr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule
